// File: rtl/rob_multi.sv
// Reorder buffer: in-order issue, out-of-order writeback, up to CW in-order commits
// per cycle, branch-mispredict flush and a JALR in-flight counter driving melt.
`timescale 1ns/1ps
module rob_multi #(
  parameter  int DEPTH = 16,
  parameter  int CW    = 2,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  output logic               issue_ready,
  output logic [IW-1:0]      issue_id,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_pc,
  input  logic [31:0]        issue_pred,
  input  logic [31:0]        issue_val,
  input  logic               wb0_valid,
  input  logic [IW-1:0]      wb0_id,
  input  logic [31:0]        wb0_val,
  input  logic               wb1_valid,
  input  logic [IW-1:0]      wb1_id,
  input  logic [31:0]        wb1_val,
  input  logic [IW-1:0]      q1_id,
  input  logic [IW-1:0]      q2_id,
  output logic               q1_ready,
  output logic               q2_ready,
  output logic [31:0]        q1_val,
  output logic [31:0]        q2_val,
  output logic [CW-1:0]      cm_valid,
  output logic [CW*IW-1:0]   cm_id,
  output logic [CW*5-1:0]    cm_rd,
  output logic [CW*32-1:0]   cm_val,
  output logic               store_go,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic               melt,
  output logic [IW:0]        count
);

  typedef enum logic [1:0] {E_EMPTY, E_ISSUED, E_DONE} ent_state_e;
  typedef enum logic [1:0] {T_BR = 2'd0, T_ST = 2'd1, T_JALR = 2'd2, T_RG = 2'd3} itype_e;

  localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);

  ent_state_e    ent_state [DEPTH];
  itype_e        ent_type  [DEPTH];
  logic [4:0]    ent_rd    [DEPTH];
  logic [31:0]   ent_pred  [DEPTH];
  logic [31:0]   ent_val   [DEPTH];

  logic [IW-1:0] head, tail, head1;
  logic [IW:0]   jalr_cnt, n_commit, n_jalr_done;
  itype_e        t0, t1;
  logic          fire, go0, go1, mis0, mis1;
  logic [1:0]    vld_vec;
  logic [2*IW-1:0] id_vec;
  logic [9:0]    rd_vec;
  logic [63:0]   val_vec;

  // The fetch pc travels with the instruction but nothing here consumes it.
  logic unused_pc;
  assign unused_pc = ^issue_pc;

  assign issue_id = tail;
  assign melt     = (jalr_cnt == '0);
  assign q1_ready = (ent_state[q1_id] == E_DONE);
  assign q2_ready = (ent_state[q2_id] == E_DONE);
  assign q1_val   = ent_val[q1_id];
  assign q2_val   = ent_val[q2_id];

  // NOTE: every signal written here gets an unconditional value, so no latch can be inferred.
  always_comb begin
    issue_ready = (count < FULL_CNT) && !flush;
    fire        = issue_valid && issue_ready && rdy_in;
    head1       = head + IW'(1);
    t0          = ent_type[head];
    t1          = ent_type[head1];
    mis0        = (t0 == T_BR) && (ent_val[head]  != ent_pred[head]);
    mis1        = (t1 == T_BR) && (ent_val[head1] != ent_pred[head1]);
    go0         = !flush && (ent_state[head] == E_DONE);
    // A second retire never follows a mispredict and never pairs two stores.
    go1         = (CW == 2) && go0 && (ent_state[head1] == E_DONE) && !mis0 &&
                  !((t0 == T_ST) && (t1 == T_ST));
    vld_vec     = {go1 && (t1 == T_RG || t1 == T_JALR), go0 && (t0 == T_RG || t0 == T_JALR)};
    n_commit    = (IW+1)'(go0) + (IW+1)'(go1);
    n_jalr_done = (IW+1)'(go0 && t0 == T_JALR) + (IW+1)'(go1 && t1 == T_JALR);
    id_vec      = {head1, head};
    rd_vec      = {ent_rd[head1], ent_rd[head]};
    val_vec     = {ent_val[head1], ent_val[head]};
  end

  // NOTE: sequential state uses non-blocking assignments, so every read in this block sees pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_state[i] <= E_EMPTY;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      jalr_cnt <= '0;
      cm_valid <= '0;
      cm_id    <= '0;
      cm_rd    <= '0;
      cm_val   <= '0;
      store_go <= 1'b0;
      flush    <= 1'b0;
      flush_pc <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent_state[i] <= E_EMPTY;
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        jalr_cnt <= '0;
        cm_valid <= '0;
        store_go <= 1'b0;
        flush    <= 1'b0;
      end else begin
        if (fire) begin
          ent_state[tail] <= E_ISSUED;
          tail            <= tail + IW'(1);
        end
        if (wb0_valid && ent_state[wb0_id] != E_EMPTY) ent_state[wb0_id] <= E_DONE;
        if (wb1_valid && ent_state[wb1_id] != E_EMPTY) ent_state[wb1_id] <= E_DONE;
        if (go0) ent_state[head]  <= E_EMPTY;
        if (go1) ent_state[head1] <= E_EMPTY;
        head     <= head + n_commit[IW-1:0];
        count    <= count + (IW+1)'(fire) - n_commit;
        jalr_cnt <= jalr_cnt + (IW+1)'(fire && itype_e'(issue_type) == T_JALR) - n_jalr_done;
        cm_valid <= vld_vec[CW-1:0];
        cm_id    <= id_vec[CW*IW-1:0];
        cm_rd    <= rd_vec[CW*5-1:0];
        cm_val   <= val_vec[CW*32-1:0];
        store_go <= (go0 && t0 == T_ST) || (go1 && t1 == T_ST);
        flush    <= (go0 && mis0) || (go1 && mis1);
        if (go0 && mis0)      flush_pc <= ent_val[head];
        else if (go1 && mis1) flush_pc <= ent_val[head1];
      end
    end
  end

  // NOTE: payload arrays carry no reset; they are only read while the entry state (which is reset) says ISSUED or DONE.
  always_ff @(posedge clk_in) begin
    if (fire) begin
      ent_type[tail] <= itype_e'(issue_type);
      ent_rd[tail]   <= issue_rd;
      ent_pred[tail] <= issue_pred;
      ent_val[tail]  <= issue_val;
    end
    if (rdy_in && !flush) begin
      if (wb0_valid && ent_state[wb0_id] != E_EMPTY) ent_val[wb0_id] <= wb0_val;
      if (wb1_valid && ent_state[wb1_id] != E_EMPTY) ent_val[wb1_id] <= wb1_val;
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi (DEPTH=16, CW=2): commit order, full/wrap,
// mispredict flush, store pacing, JALR melt, rdy_in hold and reset.
`timescale 1ns/1ps
module tb_rob_multi;
  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int IW    = 4;
  localparam logic [1:0] BR = 2'd0, ST = 2'd1, JALR = 2'd2, RG = 2'd3;

  logic              clk_in, rst_in, rdy_in;
  logic              issue_valid, issue_ready;
  logic [IW-1:0]     issue_id;
  logic [1:0]        issue_type;
  logic [4:0]        issue_rd;
  logic [31:0]       issue_pc, issue_pred, issue_val;
  logic              wb0_valid, wb1_valid;
  logic [IW-1:0]     wb0_id, wb1_id;
  logic [31:0]       wb0_val, wb1_val;
  logic [IW-1:0]     q1_id, q2_id;
  logic              q1_ready, q2_ready;
  logic [31:0]       q1_val, q2_val;
  logic [CW-1:0]     cm_valid;
  logic [CW*IW-1:0]  cm_id;
  logic [CW*5-1:0]   cm_rd;
  logic [CW*32-1:0]  cm_val;
  logic              store_go, flush, melt;
  logic [31:0]       flush_pc;
  logic [IW:0]       count;

  int n_cmp = 0;
  int n_bad = 0;

  rob_multi #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_id(issue_id),
    .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred(issue_pred), .issue_val(issue_val),
    .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
    .wb1_valid(wb1_valid), .wb1_id(wb1_id), .wb1_val(wb1_val),
    .q1_id(q1_id), .q2_id(q2_id), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .cm_valid(cm_valid), .cm_id(cm_id), .cm_rd(cm_rd), .cm_val(cm_val),
    .store_go(store_go), .flush(flush), .flush_pc(flush_pc), .melt(melt), .count(count)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pred);
    issue_valid = 1'b1;
    issue_type  = t;
    issue_rd    = rd;
    issue_pc    = 32'h1000;
    issue_pred  = pred;
    issue_val   = 32'hdead;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic clear_wb();
    wb0_valid = 1'b0;
    wb1_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1;
    issue_valid = 1'b0; issue_type = RG; issue_rd = '0; issue_pc = '0; issue_pred = '0; issue_val = '0;
    wb0_valid = 1'b0; wb0_id = '0; wb0_val = '0;
    wb1_valid = 1'b0; wb1_id = '0; wb1_val = '0;
    q1_id = '0; q2_id = '0;
    repeat (2) @(negedge clk_in);
    check("rst_count", count, 0);
    check("rst_issue_ready", issue_ready, 1);
    check("rst_melt", melt, 1);
    check("rst_flush", flush, 0);
    check("rst_flush_pc", flush_pc, 0);
    check("rst_cm_valid", cm_valid, 0);
    check("rst_store_go", store_go, 0);
    check("rst_issue_id", issue_id, 0);
    rst_in = 1'b1;
    tick();

    // Three RG, writebacks out of order, paired then single commit
    do_issue(RG, 5'd1, 0);
    do_issue(RG, 5'd2, 0);
    do_issue(RG, 5'd3, 0);
    check("t1_count3", count, 3);
    check("t1_issue_id", issue_id, 3);
    q1_id = 4'd2;
    check("t1_q1_not_ready", q1_ready, 0);
    wb0_valid = 1; wb0_id = 4'd2; wb0_val = 32'hA;
    tick(); clear_wb();
    check("t1_q1_ready", q1_ready, 1);
    check("t1_q1_val", q1_val, 32'hA);
    check("t1_no_commit", cm_valid, 0);
    wb0_valid = 1; wb0_id = 4'd0; wb0_val = 32'hB;
    wb1_valid = 1; wb1_id = 4'd1; wb1_val = 32'hC;
    tick(); clear_wb();
    check("t1_wb_no_commit", cm_valid, 0);
    tick();
    check("t1_c1_valid", cm_valid, 2'b11);
    check("t1_c1_id", cm_id, 8'h10);
    check("t1_c1_rd", cm_rd, 10'h041);
    check("t1_c1_val", cm_val, 64'h0000000C_0000000B);
    check("t1_c1_count", count, 1);
    tick();
    check("t1_c2_valid", cm_valid, 2'b01);
    check("t1_c2_id", cm_id[3:0], 2);
    check("t1_c2_rd", cm_rd[4:0], 3);
    check("t1_c2_val", cm_val[31:0], 32'hA);
    check("t1_c2_count", count, 0);
    tick();
    check("t1_idle_valid", cm_valid, 0);

    // Same-id dual writeback, no bypass, writeback to an empty entry
    do_issue(RG, 5'd4, 0);
    do_issue(RG, 5'd5, 0);
    q1_id = 4'd4; q2_id = 4'd3;
    wb0_valid = 1; wb0_id = 4'd4; wb0_val = 32'h11;
    wb1_valid = 1; wb1_id = 4'd4; wb1_val = 32'h22;
    tick(); clear_wb();
    check("t2_q1_ready", q1_ready, 1);
    check("t2_q1_val_wb1_wins", q1_val, 32'h22);
    check("t2_q2_ready", q2_ready, 0);
    wb0_valid = 1; wb0_id = 4'd3; wb0_val = 32'h33;
    wb1_valid = 1; wb1_id = 4'd9; wb1_val = 32'h55;
    #1;
    check("t2_no_bypass", q2_ready, 0);
    tick(); clear_wb();
    q1_id = 4'd9;
    check("t2_q2_ready_after", q2_ready, 1);
    check("t2_q2_val", q2_val, 32'h33);
    check("t2_wb_empty_ignored", q1_ready, 0);
    tick();
    check("t2_valid", cm_valid, 2'b11);
    check("t2_val", cm_val, 64'h00000022_00000033);
    check("t2_rd", cm_rd, 10'h0A4);
    check("t2_count", count, 0);

    // JALR melt and rdy_in hold (including strobes)
    do_issue(JALR, 5'd7, 0);
    check("t3_melt_low", melt, 0);
    check("t3_count", count, 1);
    wb0_valid = 1; wb0_id = 4'd5; wb0_val = 32'h77;
    tick(); clear_wb();
    check("t3_melt_still_low", melt, 0);
    tick();
    check("t3_cm_valid", cm_valid, 2'b01);
    check("t3_cm_id", cm_id[3:0], 5);
    check("t3_cm_rd", cm_rd[4:0], 7);
    check("t3_cm_val", cm_val[31:0], 32'h77);
    check("t3_melt_high", melt, 1);
    rdy_in = 1'b0;
    issue_valid = 1; issue_type = JALR;
    wb0_valid = 1; wb0_id = 4'd6; wb0_val = 32'h66;
    repeat (3) tick();
    check("t3_hold_cm_valid", cm_valid, 2'b01);
    check("t3_hold_count", count, 0);
    check("t3_hold_issue_id", issue_id, 6);
    check("t3_hold_melt", melt, 1);
    rdy_in = 1'b1; issue_valid = 0; clear_wb();
    tick();
    check("t3_resume_cm_valid", cm_valid, 0);

    // Two adjacent stores retire one per cycle
    do_issue(ST, 5'd0, 0);
    do_issue(ST, 5'd0, 0);
    wb0_valid = 1; wb0_id = 4'd6; wb0_val = 32'h1;
    wb1_valid = 1; wb1_id = 4'd7; wb1_val = 32'h2;
    tick(); clear_wb();
    check("t4_sg_idle", store_go, 0);
    tick();
    check("t4_sg_first", store_go, 1);
    check("t4_cm_valid", cm_valid, 0);
    check("t4_count1", count, 1);
    tick();
    check("t4_sg_second", store_go, 1);
    check("t4_count0", count, 0);
    tick();
    check("t4_sg_done", store_go, 0);

    // Mispredicted branch with a DONE younger RG and a JALR in flight
    do_issue(BR, 5'd0, 32'h100);
    do_issue(RG, 5'd9, 0);
    do_issue(JALR, 5'd10, 0);
    check("t5_count3", count, 3);
    wb0_valid = 1; wb0_id = 4'd8; wb0_val = 32'h200;
    wb1_valid = 1; wb1_id = 4'd9; wb1_val = 32'h99;
    tick(); clear_wb();
    tick();
    check("t5_flush", flush, 1);
    check("t5_flush_pc", flush_pc, 32'h200);
    check("t5_rg_not_committed", cm_valid, 0);
    check("t5_count2", count, 2);
    check("t5_ready_low", issue_ready, 0);
    check("t5_melt_low", melt, 0);
    issue_valid = 1; issue_type = RG;
    wb0_valid = 1; wb0_id = 4'd10; wb0_val = 32'h5;
    tick(); issue_valid = 0; clear_wb();
    check("t5_flush_clear", flush, 0);
    check("t5_count0", count, 0);
    check("t5_issue_id0", issue_id, 0);
    check("t5_ready_high", issue_ready, 1);
    check("t5_melt_reset", melt, 1);
    check("t5_post_cm_valid", cm_valid, 0);

    // Correctly predicted branch: silent commit
    do_issue(BR, 5'd0, 32'h40);
    wb0_valid = 1; wb0_id = 4'd0; wb0_val = 32'h40;
    tick(); clear_wb();
    tick();
    check("t5b_no_flush", flush, 0);
    check("t5b_cm_valid", cm_valid, 0);
    check("t5b_count", count, 0);

    // Fill to DEPTH, tail wrap, commit frees space only next cycle
    issue_valid = 1; issue_type = RG;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("t6_tail_wrap", issue_id, 0);
      issue_rd = 5'(i);
      tick();
    end
    check("t6_full_count", count, 16);
    check("t6_full_ready", issue_ready, 0);
    check("t6_full_issue_id", issue_id, 1);
    tick();
    check("t6_full_hold", count, 16);
    wb0_valid = 1; wb0_id = 4'd1; wb0_val = 32'h111;
    wb1_valid = 1; wb1_id = 4'd2; wb1_val = 32'h222;
    tick(); clear_wb();
    check("t6_wb_count", count, 16);
    tick();
    check("t6_commit_valid", cm_valid, 2'b11);
    check("t6_commit_id", cm_id, 8'h21);
    check("t6_commit_count", count, 14);
    check("t6_ready_again", issue_ready, 1);
    tick();
    issue_valid = 0;
    check("t6_refill_count", count, 15);

    // Reset mid-operation discards DONE entries without commits
    wb0_valid = 1; wb0_id = 4'd3; wb0_val = 32'h333;
    wb1_valid = 1; wb1_id = 4'd4; wb1_val = 32'h444;
    tick(); clear_wb();
    rst_in = 1'b0;
    #1;
    check("t7_async_count", count, 0);
    check("t7_async_ready", issue_ready, 1);
    tick();
    rst_in = 1'b1;
    q1_id = 4'd3;
    tick();
    check("t7_cm_valid", cm_valid, 0);
    check("t7_count", count, 0);
    check("t7_entry_cleared", q1_ready, 0);
    check("t7_store_go", store_go, 0);
    check("t7_melt", melt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
ROB_MULTI -- requirements
Module: rob_multi

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, 4..64.
REQ-002 SHALL have parameter CW, default 2, max commits per cycle; legal values 1 or 2.
REQ-003 SHALL derive IW = log2(DEPTH) as the entry-id width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk_in  in  1  system clock, rising edge.
REQ-006 rst_in  in  1  asynchronous reset, active low.
REQ-007 rdy_in  in  1  global enable; all state frozen when low.
REQ-008 issue_valid  in  1  decoder presents an instruction.
REQ-009 issue_ready  out  1  entry free (count < DEPTH) and flush low.
REQ-010 issue_id  out  IW  id allocated to the current issue (= tail).
REQ-011 issue_type  in  2  0 BR, 1 ST, 2 JALR, 3 RG.
REQ-012 issue_rd / issue_pc / issue_pred / issue_val  in  5/32/32/32  destination, pc, predicted target, initial value.
REQ-013 wb0_valid / wb0_id / wb0_val  in  1/IW/32  RS writeback.
REQ-014 wb1_valid / wb1_id / wb1_val  in  1/IW/32  LSB writeback.
REQ-015 q1_id / q2_id  in  IW  operand queries; q1_ready / q2_ready out 1; q1_val / q2_val out 32; combinational from registered state.
REQ-016 cm_valid  out  CW  per-slot commit strobe (registered, 1-cycle pulse).
REQ-017 cm_id / cm_rd / cm_val  out  CW*IW / CW*5 / CW*32  per-slot committed id, rd, value; slot k in bits [k*w +: w].
REQ-018 store_go  out  1  1-cycle pulse: LSB may perform the store just committed.
REQ-019 flush / flush_pc  out  1/32  mispredict pulse and corrected target.
REQ-020 melt  out  1  low while any JALR is in flight.
REQ-021 count  out  IW+1  current occupancy.

Function
REQ-022 Entry state SHALL be EMPTY, ISSUED or DONE; issue sets ISSUED at tail, tail += 1 mod DEPTH.
REQ-023 Issue SHALL occur only when issue_valid && issue_ready && rdy_in; otherwise ignored, no state change.
REQ-024 A writeback SHALL set DONE and store its value; writebacks to EMPTY entries SHALL be ignored.
REQ-025 wb0 and wb1 to the same id in one cycle: wb1 value SHALL win.
REQ-026 qN_ready SHALL be 1 iff entry qN_id is DONE; qN_val = stored value; no same-cycle writeback bypass.
REQ-027 Commit slot 0 SHALL retire head when DONE; slot 1 (CW=2) SHALL retire head+1 only if slot 0 retires, head+1 DONE, slot 0 not a mispredicted BR, and not both ST.
REQ-028 Retired entries SHALL become EMPTY; head advances by commits mod DEPTH; count = count + issued - committed.
REQ-029 RG and JALR commits SHALL drive cm_valid/id/rd/val next cycle; BR and ST commits SHALL leave that slot's cm_valid 0.
REQ-030 ST commit SHALL pulse store_go one cycle after commit.
REQ-031 BR with value != predicted target SHALL pulse flush, flush_pc = value, one cycle after commit; younger entries SHALL not commit that cycle.
REQ-032 While flush = 1 and rdy_in = 1, next edge SHALL empty all entries, head = tail = count = 0, JALR counter = 0, flush = 0; issue and writebacks that cycle ignored.
REQ-033 A JALR counter SHALL increment on JALR issue, decrement on JALR commit (net on same cycle); melt = (counter == 0).
REQ-034 Full (count == DEPTH): issue_ready = 0; commit the same cycle frees space only from the next cycle.
REQ-035 Pointers SHALL wrap at DEPTH; full/empty distinguished by count, not pointer equality.
REQ-036 rdy_in low SHALL hold all registers, including strobes, unchanged.

Reset
REQ-037 rst_in low SHALL asynchronously clear all entries to EMPTY, head, tail, count, JALR counter, cm_*, store_go, flush, flush_pc to 0; melt = 1, issue_ready = 1.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight entries with no commit strobes emitted.

Verification
REQ-039 Issue 3 RG (rd 1,2,3), writeback ids 2,0,1 values 0xA,0xB,0xC -> commits in id order; CW=2: ids 0,1 one cycle, id 2 next; cm_val 0xB,0xC,0xA.
REQ-040 Fill DEPTH entries -> issue_ready 0, count = DEPTH; commit 2 -> issue_ready 1 next cycle; tail wraps to 0.
REQ-041 BR pred 0x100, wb value 0x200, younger RG DONE -> flush = 1, flush_pc = 0x200, RG not committed; next cycle count = 0.
REQ-042 Two adjacent DONE ST at head -> one per cycle, two store_go pulses on consecutive cycles.
REQ-043 Issue JALR -> melt 0; commit it -> melt 1 next cycle; rdy_in low 3 cycles mid-sequence -> no state change.
REQ-044 wb0 and wb1 both id 4 values 0x11/0x22 -> q1_val for id 4 = 0x22.
